// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: register address, the zero register and the
// multiply/divide occupancy FSM state encoding.
package cpu_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef enum logic {
        HZ_IDLE,
        HZ_BUSY
    } hz_state_t;

endpackage

// File: rtl/muldiv_tracker.sv
// Multiply/divide occupancy tracker: an IDLE/BUSY FSM with a down-counter.
// MulDivBusy is high for exactly LAT-1 cycles after the start edge. Only
// instantiated when HAZARD_MULDIV_EN is defined.
module muldiv_tracker
    import cpu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MulStart_EX,
    input  logic DivStart_EX,
    output logic MulDivBusy
);

    localparam int unsigned CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: divide wins over multiply; starts while busy are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            HZ_IDLE: begin
                if (DivStart_EX) begin
                    state_d = HZ_BUSY;
                    cnt_d   = DIV_INIT;
                end else if (MulStart_EX) begin
                    state_d = HZ_BUSY;
                    cnt_d   = MUL_INIT;
                end
            end
            HZ_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = HZ_IDLE;
                end
            end
            default: begin
                state_d = HZ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign MulDivBusy = (state_q == HZ_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard and stall controller: load-use stalls, taken-branch
// flushes and HI/LO stalls behind the multi-cycle multiply/divide unit.
// Define HAZARD_MULDIV_EN to build the multiply/divide occupancy tracker;
// without it MulDivBusy is tied low and the HI/LO inputs are ignored.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       UseRs_ID,
    input  logic       UseRt_ID,
    input  logic       HiLoUse_ID,
    input  logic       MemRead_EX,
    input  logic [4:0] RegWtaddr_EX,
    input  logic       BranchTaken_EX,
    input  logic       MulStart_EX,
    input  logic       DivStart_EX,
    output logic       PCWrite_en,
    output logic       IFID_Write_en,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       MulDivBusy
);

    logic load_use;
    logic hilo_stall;
    logic stall;

`ifdef HAZARD_MULDIV_EN
    muldiv_tracker #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) u_muldiv_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .MulStart_EX(MulStart_EX),
        .DivStart_EX(DivStart_EX),
        .MulDivBusy (MulDivBusy)
    );

    assign hilo_stall = HiLoUse_ID && MulDivBusy;
`else
    // Single-cycle multiply/divide: no occupancy to track.
    logic unused_muldiv;
    assign unused_muldiv = ^{clk, rst_n, MulStart_EX, DivStart_EX, HiLoUse_ID};
    assign MulDivBusy    = 1'b0;
    assign hilo_stall    = 1'b0;
`endif

    // A load writing $zero never creates a real dependency.
    assign load_use = MemRead_EX && (reg_addr_t'(RegWtaddr_EX) != REG_ZERO) &&
                      ((UseRs_ID && (Rs_ID == RegWtaddr_EX)) ||
                       (UseRt_ID && (Rt_ID == RegWtaddr_EX)));

    assign stall = load_use || hilo_stall;

    // Pipeline control: taken branch discards the ID instruction, so it beats stall.
    always_comb begin
        PCWrite_en    = 1'b1;
        IFID_Write_en = 1'b1;
        IFID_Flush    = 1'b0;
        IDEX_Flush    = 1'b0;
        if (BranchTaken_EX) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (stall) begin
            PCWrite_en    = 1'b0;
            IFID_Write_en = 1'b0;
            IDEX_Flush    = 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

ID-stage hazard and stall controller for the five-stage MIPS pipeline. Where EX-stage forwarding resolves RAW dependencies, this block handles the cases forwarding cannot: load-use hazards, taken-branch flushes, and HI/LO hazards from the multi-cycle multiply/divide unit. It drives the PC, IF/ID and ID/EX pipeline-register enables and flushes, and tracks multiply/divide occupancy with a small FSM and counter.

## Interface
Parameters:
- MUL_LAT, 4: multiply latency in cycles, ≥2.
- DIV_LAT, 32: divide latency in cycles, ≥2.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- Rs_ID  in  5  rs field of the instruction in ID.
- Rt_ID  in  5  rt field of the instruction in ID.
- UseRs_ID  in  1  the ID instruction reads rs.
- UseRt_ID  in  1  the ID instruction reads rt.
- HiLoUse_ID  in  1  the ID instruction is MFHI/MFLO/MTHI/MTLO or a mul/div.
- MemRead_EX  in  1  the EX instruction is a load.
- RegWtaddr_EX  in  5  destination register of the EX instruction.
- BranchTaken_EX  in  1  the branch/jump in EX resolved taken.
- MulStart_EX  in  1  a multiply issues from EX this cycle.
- DivStart_EX  in  1  a divide issues from EX this cycle.
- PCWrite_en  out  1  PC update enable.
- IFID_Write_en  out  1  IF/ID register hold control; 0 = hold.
- IFID_Flush  out  1  clear IF/ID to a NOP.
- IDEX_Flush  out  1  insert a bubble into ID/EX.
- MulDivBusy  out  1  the multiply/divide unit is occupied (registered).

## Operation
- load_use = MemRead_EX && RegWtaddr_EX!=0 && ((UseRs_ID && Rs_ID==RegWtaddr_EX) || (UseRt_ID && Rt_ID==RegWtaddr_EX)).
- hilo_stall = HiLoUse_ID && MulDivBusy.
- stall = load_use || hilo_stall.
- Priority 1, BranchTaken_EX: IFID_Flush=1, IDEX_Flush=1, PCWrite_en=1, IFID_Write_en=1. Any stall in the same cycle is dropped, because the ID instruction is discarded.
- Priority 2, stall: PCWrite_en=0, IFID_Write_en=0, IDEX_Flush=1, IFID_Flush=0.
- Otherwise: PCWrite_en=1, IFID_Write_en=1, both flushes 0.
- FSM states are IDLE and BUSY. A down-counter cnt of width $clog2(DIV_LAT) tracks occupancy.
  - IDLE → BUSY on MulStart_EX (cnt ← MUL_LAT-1) or DivStart_EX (cnt ← DIV_LAT-1).
  - If both starts are asserted together, divide wins.
  - BUSY: cnt decrements each cycle. At cnt==1 the next state is IDLE.
  - A start in BUSY is ignored. It cannot occur legally, because hilo_stall holds any mul/div in ID.
- MulDivBusy = (state==BUSY).
- A taken branch does not abort an operation in progress.
- Reset, including mid-operation: state=IDLE, cnt=0. The stall and flush outputs are combinational; with all inputs at 0 they read PCWrite_en=1, IFID_Write_en=1, IFID_Flush=0, IDEX_Flush=0, MulDivBusy=0.

## Timing
- PCWrite_en, IFID_Write_en, IFID_Flush and IDEX_Flush are combinational from the inputs and state, with zero-cycle latency, and are sampled by the pipeline registers at the next clk edge.
- A load-use stall lasts exactly 1 cycle. The bubble clears MemRead_EX on the following cycle.
- MulDivBusy rises the cycle after the start edge and stays high for exactly LAT-1 cycles.
- HI/LO is readable by an instruction in EX during the first cycle MulDivBusy is low.
- hilo_stall persists for as many cycles as needed.

## Configuration
- HAZARD_MULDIV_EN defined: FSM, counter and hilo_stall are present as described.
- HAZARD_MULDIV_EN undefined: FSM and counter are removed, MulDivBusy is tied to 0, hilo_stall=0, and MulStart_EX/DivStart_EX/HiLoUse_ID are ignored. Multiply/divide is then assumed to be single-cycle.

## Structure
- The shared package cpu_pkg holds:
  - typedef reg_addr_t (5 bits);
  - constant REG_ZERO=0;
  - the FSM state enum hz_state_t {HZ_IDLE, HZ_BUSY}.
- Sub-module muldiv_tracker contains the FSM, the counter and MulDivBusy, with inputs MulStart_EX/DivStart_EX. It is instantiated only under HAZARD_MULDIV_EN.
- The top level combines load_use, hilo_stall and branch priority.

## Test plan
- Load-use: MemRead_EX=1, RegWtaddr_EX=8, Rs_ID=8, UseRs_ID=1 → one cycle with PCWrite_en=0, IFID_Write_en=0, IDEX_Flush=1; the next cycle (MemRead_EX=0) returns to normal.
- Zero register: same as load-use but with RegWtaddr_EX=0, Rs_ID=0 → no stall. Also UseRt_ID=0 with a matching Rt_ID=8 → no stall.
- Branch over stall: load_use condition true together with BranchTaken_EX=1 → IFID_Flush=1, IDEX_Flush=1, PCWrite_en=1.
- Divide: DivStart_EX pulse with DIV_LAT=32 → MulDivBusy high for exactly 31 cycles. HiLoUse_ID=1 throughout → stall for all 31 cycles, and release on the cycle MulDivBusy falls.
- Simultaneous starts: MulStart_EX=1 and DivStart_EX=1 together → MulDivBusy high for 31 cycles (divide latency, not 3).
- Reset mid-divide: rst_n low 5 cycles after DivStart_EX → MulDivBusy=0 immediately (asynchronous), all stall/flush outputs at their reset values, and the FSM is in IDLE after rst_n releases.
